serial_tc_ctrl: RTL and testbench

SERIAL_TC_CTRL -- requirements
Module: serial_tc_ctrl

---
 rtl/serial_tc_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_tc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tc_ctrl.sv
// Controller that streams a word LSB-first into an external bit-serial two's
// complementer and reassembles the returned serial bits into a parallel result.
module serial_tc_ctrl #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] din,
  output logic         ser_i,
  output logic         ser_r,
  input  logic         ser_y,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          drive_v;
  logic          cap_v;

  assign drive_v = (state_q == SHIFT);

  // cap_v marks the cycle in which ser_y carries the result of a driven bit.
  if (LAT == 0) begin : g_nolat
    assign cap_v = drive_v;
  end else begin : g_lat
    logic [LAT-1:0] vld_q;

    always_ff @(posedge t_clk or posedge r) begin
      if (r) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= drive_v;
        for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    assign cap_v = vld_q[LAT-1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    start_ready = 1'b0;
    ser_i       = 1'b0;
    ser_r       = 1'b0;
    dout_valid  = 1'b0;
    busy        = 1'b1;

    if (cap_v) begin
      for (int k = 0; k < W; k++) begin
        if (rx_cnt_q == CW'(k)) rx_d[k] = ser_y;
      end
      rx_cnt_d = rx_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          tx_d     = din;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        ser_i    = tx_q[0];
        ser_r    = (tx_cnt_q == '0);
        tx_d     = tx_q >> 1;
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == LAST) state_d = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        // Leave as the final sample lands so DONE follows it directly.
        if (cap_v && rx_cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout = rx_q;

endmodule

// File: tb/tb_serial_tc_ctrl.sv
// Bench for serial_tc_ctrl: three instances (LAT=1,0,3) each driven by a
// bit-serial complementer model; results compared against -din mod 256.
module tb_serial_tc_ctrl;

  logic                t_clk = 1'b0;
  logic                r;
  logic [2:0]          start_valid, start_ready, ser_i, ser_r, ser_y;
  logic [2:0]          dout_valid, dout_ready, busy;
  logic [2:0][7:0]     din, dout;

  int n_pass  = 0;
  int n_total = 0;

  always #5 t_clk = ~t_clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    serial_tc_ctrl #(.W(8), .LAT(L)) dut (
      .t_clk      (t_clk),
      .r          (r),
      .start_valid(start_valid[g]),
      .start_ready(start_ready[g]),
      .din        (din[g]),
      .ser_i      (ser_i[g]),
      .ser_r      (ser_r[g]),
      .ser_y      (ser_y[g]),
      .dout       (dout[g]),
      .dout_valid (dout_valid[g]),
      .dout_ready (dout_ready[g]),
      .busy       (busy[g])
    );

    // Serial negation: copy bits up to and including the first 1, invert after.
    logic seen = 1'b0;
    logic y_now;
    assign y_now = ser_i[g] ^ (ser_r[g] ? 1'b0 : seen);
    always @(posedge t_clk) seen <= ser_r[g] ? ser_i[g] : (seen | ser_i[g]);

    if (L == 0) begin : g_comb
      assign ser_y[g] = y_now;
    end else begin : g_pipe
      logic [L-1:0] yp = '0;
      always @(posedge t_clk) begin
        yp[0] <= y_now;
        for (int k = 1; k < L; k++) yp[k] <= yp[k-1];
      end
      assign ser_y[g] = yp[L-1];
    end
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] neg8(input logic [7:0] d);
    return 8'((256 - int'(d)) % 256);
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic wait_done(input int i, output logic [7:0] got, output int lat,
                           output logic [15:0] sers, output logic [15:0] serr);
    lat  = 0;
    sers = '0;
    serr = '0;
    while (!dout_valid[i] && lat < 64) begin
      if (lat < 16) begin
        sers[lat] = ser_i[i];
        serr[lat] = ser_r[i];
      end
      @(posedge t_clk);
      lat++;
      @(negedge t_clk);
    end
    got = dout[i];
  endtask

  task automatic do_op(input int i, input logic [7:0] d, output logic [7:0] got,
                       output int lat, output logic [15:0] sers, output logic [15:0] serr);
    int guard = 0;
    while (!start_ready[i] && guard < 50) begin
      @(negedge t_clk);
      guard++;
    end
    start_valid[i] = 1'b1;
    din[i]         = d;
    @(posedge t_clk);
    @(negedge t_clk);
    start_valid[i] = 1'b0;
    din[i]         = 8'($urandom);
    wait_done(i, got, lat, sers, serr);
  endtask

  task automatic release_done(input int i);
    dout_ready[i] = 1'b1;
    @(posedge t_clk);
    @(negedge t_clk);
    dout_ready[i] = 1'b0;
  endtask

  task automatic test_reset;
    n_total++;
    if (start_ready !== 3'b111) $display("FAIL rst_start_ready: got %b expected 111", start_ready); else n_pass++;
    n_total++;
    if ({ser_i, ser_r} !== 6'b0) $display("FAIL rst_ser: got %b expected 000000", {ser_i, ser_r}); else n_pass++;
    n_total++;
    if (dout !== 24'h0) $display("FAIL rst_dout: got %h expected 000000", dout); else n_pass++;
    n_total++;
    if ({dout_valid, busy} !== 6'b0) $display("FAIL rst_valid_busy: got %b expected 000000", {dout_valid, busy}); else n_pass++;
    r = 1'b0;
  endtask

  // Directed words on every latency variant, including the first-edge start.
  task automatic test_basic;
    logic [7:0]  words [4] = '{8'h01, 8'h00, 8'h80, 8'h56};
    logic [7:0]  got;
    logic [15:0] sers, serr;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 4; w++) begin
        do_op(i, words[w], got, lat, sers, serr);
        n_total++;
        if (got !== neg8(words[w]))
          $display("FAIL basic_dout[%0d] din=%h: got %h expected %h", i, words[w], got, neg8(words[w]));
        else n_pass++;
        n_total++;
        if (lat != 8 + lat_of(i))
          $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, 8 + lat_of(i));
        else n_pass++;
        n_total++;
        if (sers !== {8'h00, words[w]} || serr !== 16'h0001)
          $display("FAIL basic_stream[%0d]: got ser_i=%h ser_r=%h expected ser_i=%h ser_r=0001",
                   i, sers, serr, {8'h00, words[w]});
        else n_pass++;
        release_done(i);
        n_total++;
        if (start_ready[i] !== 1'b1 || dout_valid[i] !== 1'b0 || busy[i] !== 1'b0)
          $display("FAIL basic_idle[%0d]: got ready=%b valid=%b busy=%b expected 1 0 0",
                   i, start_ready[i], dout_valid[i], busy[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold;
    logic [7:0]  got;
    logic [15:0] sers, serr;
    int          lat;
    do_op(0, 8'h3C, got, lat, sers, serr);
    start_valid[0] = 1'b1;
    din[0]         = 8'h11;
    for (int c = 0; c < 5; c++) begin
      @(posedge t_clk);
      @(negedge t_clk);
      n_total++;
      if (dout[0] !== 8'hC4 || dout_valid[0] !== 1'b1 || start_ready[0] !== 1'b0 || busy[0] !== 1'b1)
        $display("FAIL hold_cycle%0d: got dout=%h valid=%b ready=%b busy=%b expected C4 1 0 1",
                 c, dout[0], dout_valid[0], start_ready[0], busy[0]);
      else n_pass++;
    end
    release_done(0);
    n_total++;
    if (start_ready[0] !== 1'b1 || dout_valid[0] !== 1'b0)
      $display("FAIL hold_release: got ready=%b valid=%b expected 1 0", start_ready[0], dout_valid[0]);
    else n_pass++;
    @(posedge t_clk);
    @(negedge t_clk);
    start_valid[0] = 1'b0;
    n_total++;
    if (start_ready[0] !== 1'b0 || busy[0] !== 1'b1)
      $display("FAIL hold_next_accept: got ready=%b busy=%b expected 0 1", start_ready[0], busy[0]);
    else n_pass++;
    wait_done(0, got, lat, sers, serr);
    n_total++;
    if (got !== neg8(8'h11) || lat != 9)
      $display("FAIL hold_next_result: got %h after %0d expected %h after 9", got, lat, neg8(8'h11));
    else n_pass++;
    release_done(0);
  endtask

  task automatic test_reset_mid;
    logic [7:0]  got;
    logic [15:0] sers, serr;
    int          lat;
    start_valid[0] = 1'b1;
    din[0]         = 8'h5A;
    @(posedge t_clk);
    @(negedge t_clk);
    start_valid[0] = 1'b0;
    repeat (3) @(posedge t_clk);
    @(negedge t_clk);
    r = 1'b1;
    #1;
    n_total++;
    if (start_ready[0] !== 1'b1 || ser_i[0] !== 1'b0 || ser_r[0] !== 1'b0 ||
        dout[0] !== 8'h00 || dout_valid[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL midreset_outputs: got ready=%b ser_i=%b ser_r=%b dout=%h valid=%b busy=%b expected 1 0 0 00 0 0",
               start_ready[0], ser_i[0], ser_r[0], dout[0], dout_valid[0], busy[0]);
    else n_pass++;
    @(posedge t_clk);
    @(negedge t_clk);
    r = 1'b0;
    do_op(0, 8'h03, got, lat, sers, serr);
    n_total++;
    if (got !== 8'hFD || lat != 9)
      $display("FAIL midreset_next: got %h after %0d expected FD after 9", got, lat);
    else n_pass++;
    release_done(0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3] = '{8'h01, 8'h7F, 8'hFF};
    logic [7:0] res [$];
    int         tstamp [$];
    int         idx  = 0;
    logic       prev = 1'b0;
    dout_ready[0] = 1'b1;
    for (int c = 0; c < 200 && res.size() < 3; c++) begin
      if (dout_valid[0] && !prev) begin
        res.push_back(dout[0]);
        tstamp.push_back(c);
      end
      prev = dout_valid[0];
      if (start_ready[0]) begin
        if (idx < 3) begin
          start_valid[0] = 1'b1;
          din[0]         = words[idx];
          idx++;
        end else begin
          start_valid[0] = 1'b0;
        end
      end
      @(posedge t_clk);
      @(negedge t_clk);
    end
    start_valid[0] = 1'b0;
    dout_ready[0]  = 1'b0;
    n_total++;
    if (res.size() != 3) begin
      $display("FAIL b2b_count: got %0d results expected 3", res.size());
    end else begin
      n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (res[k] !== neg8(words[k]))
          $display("FAIL b2b_dout%0d: got %h expected %h", k, res[k], neg8(words[k]));
        else n_pass++;
      end
      for (int k = 1; k < 3; k++) begin
        n_total++;
        if (tstamp[k] - tstamp[k-1] != 11)
          $display("FAIL b2b_spacing%0d: got %0d expected 11", k, tstamp[k] - tstamp[k-1]);
        else n_pass++;
      end
    end
    @(negedge t_clk);
  endtask

  task automatic test_random;
    logic [7:0]  d, got;
    logic [15:0] sers, serr;
    int          lat, hold;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 15; n++) begin
        d = 8'($urandom);
        do_op(i, d, got, lat, sers, serr);
        n_total++;
        if (got !== neg8(d) || lat != 8 + lat_of(i))
          $display("FAIL rand[%0d] din=%h: got %h after %0d expected %h after %0d",
                   i, d, got, lat, neg8(d), 8 + lat_of(i));
        else n_pass++;
        hold = int'($urandom_range(0, 3));
        start_valid[i] = 1'b1;
        repeat (hold) begin
          @(posedge t_clk);
          @(negedge t_clk);
        end
        n_total++;
        if (dout[i] !== neg8(d) || dout_valid[i] !== 1'b1)
          $display("FAIL rand_hold[%0d]: got %h valid=%b expected %h valid=1",
                   i, dout[i], dout_valid[i], neg8(d));
        else n_pass++;
        start_valid[i] = 1'b0;
        release_done(i);
      end
    end
  endtask

  initial begin
    r           = 1'b1;
    start_valid = '0;
    dout_ready  = '0;
    din         = '0;
    repeat (2) @(negedge t_clk);
    test_reset;
    test_basic;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
